// File: rtl/repeater_pkg.sv
// Shared defaults and helper for the modulo-N repeating sequence generator.
//   MOD_DEFAULT   : sequence length N (values 0..N-1)
//   WIDTH_DEFAULT : width of the sequence value output
//   HOLD_DEFAULT  : clock cycles each value is held
//   next_val()    : wrapped increment; any value at or above mod-1 returns 0
package repeater_pkg;

    localparam int unsigned MOD_DEFAULT   = 5;
    localparam int unsigned WIDTH_DEFAULT = 3;
    localparam int unsigned HOLD_DEFAULT  = 1;

    // Values >= mod (upset state) fold to 0 together with the normal mod-1 wrap.
    function automatic logic [31:0] next_val(input logic [31:0] cur, input logic [31:0] mod);
        logic [31:0] nxt;
        if (cur >= mod - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = cur + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/repeater_prescaler.sv
// Hold-cycle prescaler: strobes adv_c once every HOLD clock cycles.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the hold counter
//   adv_c : combinational advance strobe, high on the last cycle of each hold window
// With HOLD == 1 there is no counter and adv_c is constant 1.
module repeater_prescaler #(
    parameter int unsigned HOLD = 1
) (
    input  logic clk,
    input  logic rst,
    output logic adv_c
);

    localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if (HOLD == 1) begin : g_no_hold
        // Clock and reset are not needed when every edge advances.
        logic unused_inputs;
        assign unused_inputs = clk ^ rst;
        assign adv_c         = 1'b1;
    end else begin : g_hold
        logic [HCW-1:0] hcnt_q;
        logic [HCW-1:0] hcnt_d;
        logic           last_c;

        // Count 0..HOLD-1 and strobe on the last count.
        always_comb begin
            last_c = (hcnt_q == HCW'(HOLD - 1));
            hcnt_d = hcnt_q + HCW'(1);
            if (last_c) begin
                hcnt_d = '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hcnt_q <= '0;
            end else begin
                hcnt_q <= hcnt_d;
            end
        end

        assign adv_c = last_c;
    end

endmodule

// File: rtl/repeater_5.sv
// Free-running modulo-MOD sequence generator: 0,1,..,MOD-1,0,... each value held HOLD cycles.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears value, hold counter and wrap
//   mod5cnt : current sequence value, straight from the value register
//   wrap    : one-cycle pulse on the first 0 following MOD-1
// Build option REPEATER_WRAP_PULSE_EN: when defined, wrap is a registered pulse;
// otherwise wrap is tied to 0 and costs no flops.
module repeater_5
    import repeater_pkg::*;
#(
    parameter int unsigned MOD   = MOD_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned HOLD  = HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] mod5cnt,
    output logic             wrap
);

    logic             adv_c;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    repeater_prescaler #(
        .HOLD (HOLD)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .adv_c (adv_c)
    );

    // Advance on the prescaler strobe; out-of-range values fall back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (adv_c) begin
            cnt_d = WIDTH'(next_val(32'(cnt_q), 32'(MOD)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mod5cnt = cnt_q;

`ifdef REPEATER_WRAP_PULSE_EN
    logic wrap_q;
    logic wrap_d;

    // Only a genuine MOD-1 -> 0 step pulses; reset release and upset recovery do not.
    always_comb begin
        wrap_d = adv_c && (cnt_q == WIDTH'(MOD - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_repeater_5.sv
module tb_repeater_5;

`ifdef REPEATER_WRAP_PULSE_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] cnt1;
    logic       wrap1;
    logic [2:0] cnt3;
    logic       wrap3;

    int unsigned n_cmp;
    int unsigned n_fail;
    // Edges seen since the last reset release / resync, per instance.
    int unsigned k1;
    int unsigned k3;

    repeater_5 #(.MOD(5), .WIDTH(3), .HOLD(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .mod5cnt (cnt1),
        .wrap    (wrap1)
    );

    repeater_5 #(.MOD(5), .WIDTH(3), .HOLD(3)) dut_h3 (
        .clk     (clk),
        .rst     (rst),
        .mod5cnt (cnt3),
        .wrap    (wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: after k update edges the value is floor(k/hold) mod 5.
    function automatic logic [2:0] exp_cnt(input int unsigned k, input int unsigned hold);
        return 3'((k / hold) % 5);
    endfunction

    // Reference: a wrap pulse marks every completed period, never k == 0.
    function automatic logic exp_wrap(input int unsigned k, input int unsigned hold);
        return WRAP_EN && (k != 0) && ((k % (5 * hold)) == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            k1++;
            k3++;
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (cnt1 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt1 got=%0d exp=0", cnt1);
        end
        n_cmp++;
        if (cnt3 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt3 got=%0d exp=0", cnt3);
        end
        n_cmp++;
        if (wrap1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wrap got=%0b exp=0", wrap1);
        end
        #1;
        rst = 1'b0;
        k1 = 0;
        k3 = 0;
    endtask

    task automatic test_sequence();
        logic [2:0]  prev;
        int unsigned periods;
        int unsigned over;
        prev    = cnt1;
        periods = 0;
        over    = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (cnt1 > 3'd4) over++;
            if (prev == 3'd4 && cnt1 == 3'd0) periods++;
            prev = cnt1;
            n_cmp++;
            if (cnt1 !== exp_cnt(k1, 1)) begin
                n_fail++;
                $display("FAIL seq_cnt1 k=%0d got=%0d exp=%0d", k1, cnt1, exp_cnt(k1, 1));
            end
            n_cmp++;
            if (wrap1 !== exp_wrap(k1, 1)) begin
                n_fail++;
                $display("FAIL seq_wrap1 k=%0d got=%0b exp=%0b", k1, wrap1, exp_wrap(k1, 1));
            end
        end
        n_cmp++;
        if (over != 0) begin
            n_fail++;
            $display("FAIL seq_range got=%0d values>4 exp=0", over);
        end
        n_cmp++;
        if (periods != 40) begin
            n_fail++;
            $display("FAIL seq_periods got=%0d exp=40", periods);
        end
    endtask

    task automatic test_hold3();
        for (int i = 0; i < 45; i++) begin
            step();
            n_cmp++;
            if (cnt3 !== exp_cnt(k3, 3)) begin
                n_fail++;
                $display("FAIL hold3_cnt k=%0d got=%0d exp=%0d", k3, cnt3, exp_cnt(k3, 3));
            end
            n_cmp++;
            if (wrap3 !== exp_wrap(k3, 3)) begin
                n_fail++;
                $display("FAIL hold3_wrap k=%0d got=%0b exp=%0b", k3, wrap3, exp_wrap(k3, 3));
            end
        end
    endtask

    task automatic test_async_reset();
        int unsigned d;
        int unsigned guard;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) step();
            guard = 0;
            while (cnt1 != 3'd3 && guard < 10) begin
                step();
                guard++;
            end
            n_cmp++;
            if (cnt1 != 3'd3) begin
                n_fail++;
                $display("FAIL arst_wait got=%0d exp=3 (timeout)", cnt1);
            end
            d = $urandom_range(1, 7);
            #d;
            rst = 1'b1;
            #1;
            n_cmp++;
            if (cnt1 !== 3'd0) begin
                n_fail++;
                $display("FAIL arst_cnt1 got=%0d exp=0", cnt1);
            end
            n_cmp++;
            if (cnt3 !== 3'd0) begin
                n_fail++;
                $display("FAIL arst_cnt3 got=%0d exp=0", cnt3);
            end
            n_cmp++;
            if (wrap1 !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_wrap got=%0b exp=0", wrap1);
            end
            rst = 1'b0;
            k1 = 0;
            k3 = 0;
            step();
            n_cmp++;
            if (cnt1 !== exp_cnt(k1, 1)) begin
                n_fail++;
                $display("FAIL arst_restart1 got=%0d exp=%0d", cnt1, exp_cnt(k1, 1));
            end
            n_cmp++;
            if (cnt3 !== exp_cnt(k3, 3)) begin
                n_fail++;
                $display("FAIL arst_restart3 got=%0d exp=%0d", cnt3, exp_cnt(k3, 3));
            end
            n_cmp++;
            if (wrap1 !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_release_wrap got=%0b exp=0", wrap1);
            end
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) step();
        force dut.cnt_q = 3'd6;
        #1;
        release dut.cnt_q;
        #1;
        n_cmp++;
        if (cnt1 !== 3'd6) begin
            n_fail++;
            $display("FAIL illegal_inject got=%0d exp=6", cnt1);
        end
        step();
        n_cmp++;
        if (cnt1 !== 3'd0) begin
            n_fail++;
            $display("FAIL illegal_recover got=%0d exp=0", cnt1);
        end
        n_cmp++;
        if (wrap1 !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_wrap got=%0b exp=0", wrap1);
        end
        k1 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (cnt1 !== exp_cnt(k1, 1) || wrap1 !== exp_wrap(k1, 1)) begin
                n_fail++;
                $display("FAIL illegal_resume k=%0d got=%0d/%0b exp=%0d/%0b",
                         k1, cnt1, wrap1, exp_cnt(k1, 1), exp_wrap(k1, 1));
            end
        end
    endtask

    task automatic test_wrap();
        int unsigned pulses;
        int unsigned exp_pulses;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (wrap1 === 1'b1) pulses++;
            n_cmp++;
            if (wrap1 === 1'b1 && cnt1 !== 3'd0) begin
                n_fail++;
                $display("FAIL wrap_align got=%0d exp=0", cnt1);
            end
        end
        exp_pulses = WRAP_EN ? 10 : 0;
        n_cmp++;
        if (pulses != exp_pulses) begin
            n_fail++;
            $display("FAIL wrap_count got=%0d exp=%0d", pulses, exp_pulses);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        k1     = 0;
        k3     = 0;
        rst    = 1'b1;
        test_reset();
        test_sequence();
        test_hold3();
        test_async_reset();
        test_illegal();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
